bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive cycles M1 may wait while M0 wins before M1 is forced.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports m0_req/m1_req  input  1  master requests a bus transaction (M0 = CPU data port, M1 = DMA/debug master).
REQ-005 SHALL have ports m0_addr/m1_addr  input  32  transaction byte address.
REQ-006 SHALL have ports m0_wd/m1_wd  input  32  write data.
REQ-007 SHALL have ports m0_we/m1_we  input  4  byte write enables; 4'b0 means read.
REQ-008 SHALL have ports m0_gnt/m1_gnt  output  1  combinational accept pulse, same cycle as winning request.
REQ-009 SHALL have ports m0_rd/m1_rd  output  32  returned read data.
REQ-010 SHALL have ports m0_valid/m1_valid  output  1  one-cycle completion strobe.
REQ-011 SHALL have port PrAddr  output  32  address to device bridge.
REQ-012 SHALL have port PrWD  output  32  write data to device bridge.
REQ-013 SHALL have port PrWE  output  4  byte enables to device bridge.
REQ-014 SHALL have port PrRD  input  32  combinational read data from device bridge.

Function
REQ-015 SHALL hold a master's req/addr/wd/we stable until its gnt is sampled high; arbiter SHALL NOT buffer ungranted requests.
REQ-016 SHALL grant at most one master per cycle; gnt asserted only when that master's req is high.
REQ-017 SHALL use FSM states ARB and FORCE1; ARB: M0 wins on simultaneous requests, M1 wins when M0 idle.
REQ-018 SHALL keep 3-bit saturating counter starve: +1 each cycle m1_req=1 and M1 not granted; cleared when M1 granted or m1_req=0.
REQ-019 SHALL transition ARB->FORCE1 when starve reaches STARVE_MAX; in FORCE1 M1 wins regardless of m0_req; FORCE1->ARB after that M1 grant.
REQ-020 SHALL latch the winner's id, addr, wd, we into issue register on grant edge (cycle N); bus driven from it in cycle N+1.
REQ-021 SHALL drive PrAddr=0, PrWD=0, PrWE=0 in any cycle with no issued transaction.
REQ-022 SHALL capture PrRD at end of issue cycle N+1 into return register; reads return data and mX_valid=1 in cycle N+2 to the owning master only.
REQ-023 SHALL complete writes identically (mX_valid at N+2) with mX_rd=0.
REQ-024 SHALL sustain one grant per cycle (2-stage pipeline, latency 2, throughput 1); back-to-back grants to different masters SHALL return in grant order.
REQ-025 SHALL hold mX_rd at last returned value when mX_valid=0.

Reset
REQ-026 SHALL on reset immediately force: state ARB, starve=0, issue/return registers invalid, PrAddr/PrWD/PrWE=0, m0_valid=m1_valid=0, m0_rd=m1_rd=0.
REQ-027 SHALL discard in-flight transactions on reset; no valid strobe for any transaction granted before reset.
REQ-028 SHALL NOT assert gnt while reset is high.

Verification
REQ-029 M0 alone: m0_req=1, addr=0x0000_0010, we=0, PrRD=0x1234_5678 -> m0_gnt cycle N, PrAddr=0x10 cycle N+1, m0_valid=1, m0_rd=0x1234_5678 cycle N+2.
REQ-030 Simultaneous: both req cycle N, M1 write addr=0x7f04 we=4'hf wd=0xA5 -> m0_gnt N, m1_gnt N+1, PrWE=4'hf PrAddr=0x7f04 N+2, m1_valid N+3, m1_rd=0.
REQ-031 Starvation: m0_req held high every cycle, m1_req high from cycle 0 -> M0 wins cycles 0-3, m1_gnt cycle 4 (FORCE1), M0 wins cycle 5.
REQ-032 Idle: no requests 10 cycles -> PrWE=0, PrAddr=0, no gnt, no valid.
REQ-033 Reset mid-flight: M0 granted cycle N, reset pulsed during N+1 -> PrWE=0 immediately, m0_valid never asserted, starve=0 after reset.
REQ-034 Pipelined stream: M0 read requests 0x0,0x4,0x8 consecutive cycles -> three consecutive m0_valid cycles, data in address order.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Two-master request/grant bus plus the single-transaction device bridge.
// The arbiter attaches through the slave modport; masters and bridge use master.
interface bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wd;
  logic [3:0]  m0_we;
  logic        m0_gnt;
  logic [31:0] m0_rd;
  logic        m0_valid;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wd;
  logic [3:0]  m1_we;
  logic        m1_gnt;
  logic [31:0] m1_rd;
  logic        m1_valid;

  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrWE;
  logic [31:0] PrRD;

  modport slave (
    input  m0_req, m0_addr, m0_wd, m0_we,
    input  m1_req, m1_addr, m1_wd, m1_we,
    input  PrRD,
    output m0_gnt, m0_rd, m0_valid,
    output m1_gnt, m1_rd, m1_valid,
    output PrAddr, PrWD, PrWE
  );

  modport master (
    output m0_req, m0_addr, m0_wd, m0_we,
    output m1_req, m1_addr, m1_wd, m1_we,
    output PrRD,
    input  m0_gnt, m0_rd, m0_valid,
    input  m1_gnt, m1_rd, m1_valid,
    input  PrAddr, PrWD, PrWE
  );
endinterface

// File: rtl/bus_arbiter.sv
// Fixed-priority two-master arbiter with M1 starvation guard and a
// two-stage issue/return pipeline towards the device bridge.
module bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic {
    ARB,
    FORCE1
  } state_e;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;

  logic        iss_vld_q, iss_vld_d;
  logic        iss_id_q, iss_id_d;
  logic [31:0] iss_addr_q, iss_addr_d;
  logic [31:0] iss_wd_q, iss_wd_d;
  logic [3:0]  iss_we_q, iss_we_d;

  logic        m0_valid_q, m0_valid_d;
  logic        m1_valid_q, m1_valid_d;
  logic [31:0] m0_rd_q, m0_rd_d;
  logic [31:0] m1_rd_q, m1_rd_d;

  logic        m0_gnt;
  logic        m1_gnt;
  logic [31:0] ret_data;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ARB: begin
          m0_gnt = bus.m0_req;
          m1_gnt = bus.m1_req & ~bus.m0_req;
        end
        FORCE1: begin
          m1_gnt = bus.m1_req;
          m0_gnt = bus.m0_req & ~bus.m1_req;
        end
        default: begin
          m0_gnt = 1'b0;
          m1_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.m1_req || m1_gnt) begin
      starve_d = 3'd0;
    end else if (starve_q != 3'd7) begin
      starve_d = starve_q + 3'd1;
    end

    state_d = state_q;
    unique case (state_q)
      ARB: begin
        if (starve_d != 3'd0 && starve_d >= SMAX) begin
          state_d = FORCE1;
        end
      end
      FORCE1: begin
        // M1 withdrawing also ends the forced window
        if (m1_gnt || !bus.m1_req) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    iss_vld_d  = m0_gnt | m1_gnt;
    iss_id_d   = m1_gnt;
    iss_addr_d = 32'd0;
    iss_wd_d   = 32'd0;
    iss_we_d   = 4'd0;
    unique case (1'b1)
      m1_gnt: begin
        iss_addr_d = bus.m1_addr;
        iss_wd_d   = bus.m1_wd;
        iss_we_d   = bus.m1_we;
      end
      m0_gnt: begin
        iss_addr_d = bus.m0_addr;
        iss_wd_d   = bus.m0_wd;
        iss_we_d   = bus.m0_we;
      end
      default: begin
        iss_addr_d = 32'd0;
        iss_wd_d   = 32'd0;
        iss_we_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    ret_data   = (iss_we_q == 4'd0) ? bus.PrRD : 32'd0;
    m0_valid_d = iss_vld_q & ~iss_id_q;
    m1_valid_d = iss_vld_q & iss_id_q;
    m0_rd_d    = m0_valid_d ? ret_data : m0_rd_q;
    m1_rd_d    = m1_valid_d ? ret_data : m1_rd_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      starve_q   <= 3'd0;
      iss_vld_q  <= 1'b0;
      iss_id_q   <= 1'b0;
      iss_addr_q <= 32'd0;
      iss_wd_q   <= 32'd0;
      iss_we_q   <= 4'd0;
      m0_valid_q <= 1'b0;
      m1_valid_q <= 1'b0;
      m0_rd_q    <= 32'd0;
      m1_rd_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      iss_vld_q  <= iss_vld_d;
      iss_id_q   <= iss_id_d;
      iss_addr_q <= iss_addr_d;
      iss_wd_q   <= iss_wd_d;
      iss_we_q   <= iss_we_d;
      m0_valid_q <= m0_valid_d;
      m1_valid_q <= m1_valid_d;
      m0_rd_q    <= m0_rd_d;
      m1_rd_q    <= m1_rd_d;
    end
  end

  // Issue fields are zeroed when idle, so the bridge sees 0 with no gating
  assign bus.PrAddr   = iss_addr_q;
  assign bus.PrWD     = iss_wd_q;
  assign bus.PrWE     = iss_we_q;
  assign bus.m0_gnt   = m0_gnt;
  assign bus.m1_gnt   = m1_gnt;
  assign bus.m0_valid = m0_valid_q;
  assign bus.m1_valid = m1_valid_q;
  assign bus.m0_rd    = m0_rd_q;
  assign bus.m1_rd    = m1_rd_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single read, collision, starvation,
// idle, reset mid-flight and a pipelined read stream.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  bus_arbiter_if bus ();

  bus_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.PrRD = (bus.PrAddr == 32'h10) ? 32'h1234_5678
                  : (bus.PrAddr ^ 32'hA5A5_0000);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.m0_req = 0; bus.m0_addr = 0; bus.m0_wd = 0; bus.m0_we = 0;
    bus.m1_req = 0; bus.m1_addr = 0; bus.m1_wd = 0; bus.m1_we = 0;

    // reset state, and no grant while reset is high
    cyc();
    bus.m0_req = 1;
    #1;
    chk("rst_gnt0", 32'(bus.m0_gnt), 0);
    chk("rst_praddr", bus.PrAddr, 0);
    chk("rst_prwe", 32'(bus.PrWE), 0);
    chk("rst_valid", 32'({bus.m0_valid, bus.m1_valid}), 0);
    chk("rst_rd", bus.m0_rd | bus.m1_rd, 0);
    bus.m0_req = 0;
    @(negedge clk);
    reset = 0;

    // M0 alone read
    cyc();
    bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_we = 0;
    #1;
    chk("m0_gnt_N", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    cyc();
    bus.m0_req = 0;
    chk("praddr_N1", bus.PrAddr, 32'h10);
    chk("prwe_N1", 32'(bus.PrWE), 0);
    cyc();
    chk("m0_valid_N2", 32'({bus.m0_valid, bus.m1_valid}), 32'b10);
    chk("m0_rd_N2", bus.m0_rd, 32'h1234_5678);
    cyc();
    chk("m0_valid_drop", 32'(bus.m0_valid), 0);
    chk("m0_rd_hold", bus.m0_rd, 32'h1234_5678);

    // simultaneous: M0 read wins, M1 write next cycle
    cyc();
    bus.m0_req = 1; bus.m0_addr = 32'h20; bus.m0_we = 0;
    bus.m1_req = 1; bus.m1_addr = 32'h7f04;
    bus.m1_we = 4'hf; bus.m1_wd = 32'hA5;
    #1;
    chk("sim_gnt_N", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    cyc();
    bus.m0_req = 0;
    #1;
    chk("sim_gnt_N1", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b01);
    chk("sim_praddr_N1", bus.PrAddr, 32'h20);
    cyc();
    bus.m1_req = 0;
    chk("sim_prwe_N2", 32'(bus.PrWE), 32'hf);
    chk("sim_praddr_N2", bus.PrAddr, 32'h7f04);
    chk("sim_prwd_N2", bus.PrWD, 32'hA5);
    chk("sim_m0_rd_N2", bus.m0_rd, 32'hA5A5_0020);
    cyc();
    chk("sim_m1_valid_N3", 32'({bus.m0_valid, bus.m1_valid}), 32'b01);
    chk("sim_m1_rd_N3", bus.m1_rd, 0);

    // starvation: M0 wins cycles 0-3, M1 forced at 4, M0 again at 5
    cyc();
    bus.m0_req = 1; bus.m0_addr = 32'h100; bus.m0_we = 0;
    bus.m1_req = 1; bus.m1_addr = 32'h200; bus.m1_we = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("starve_c%0d", c), 32'({bus.m0_gnt, bus.m1_gnt}),
          (c == 4) ? 32'b01 : 32'b10);
      @(negedge clk);
    end
    bus.m0_req = 0; bus.m1_req = 0;
    repeat (3) cyc();

    // idle
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("idle_ctl", 32'({bus.m0_gnt, bus.m1_gnt, bus.m0_valid,
                           bus.m1_valid, bus.PrWE}), 0);
      chk("idle_addr", bus.PrAddr, 0);
    end

    // reset mid-flight
    cyc();
    bus.m0_req = 1; bus.m0_addr = 32'h40; bus.m0_we = 4'h3;
    bus.m0_wd = 32'h55;
    bus.m1_req = 1; bus.m1_addr = 32'h80; bus.m1_we = 0;
    #1;
    chk("rmf_gnt_N", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
    cyc();
    chk("rmf_prwe_N1", 32'(bus.PrWE), 32'h3);
    chk("rmf_starve_pre", 32'(dut.starve_q), 1);
    reset = 1;
    #1;
    chk("rmf_prwe_rst", 32'(bus.PrWE), 0);
    chk("rmf_praddr_rst", bus.PrAddr, 0);
    chk("rmf_gnt_rst", 32'({bus.m0_gnt, bus.m1_gnt}), 0);
    chk("rmf_starve_rst", 32'(dut.starve_q), 0);
    bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0;
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("rmf_no_valid", 32'({bus.m0_valid, bus.m1_valid}), 0);
    end

    // pipelined M0 read stream
    cyc();
    bus.m0_req = 1; bus.m0_addr = 32'h0;
    #1;
    chk("str_gnt0", 32'(bus.m0_gnt), 1);
    cyc();
    bus.m0_addr = 32'h4;
    #1;
    chk("str_gnt1", 32'(bus.m0_gnt), 1);
    cyc();
    bus.m0_addr = 32'h8;
    #1;
    chk("str_gnt2", 32'(bus.m0_gnt), 1);
    chk("str_v0", 32'(bus.m0_valid), 1);
    chk("str_d0", bus.m0_rd, 32'hA5A5_0000);
    cyc();
    bus.m0_req = 0;
    chk("str_v1", 32'(bus.m0_valid), 1);
    chk("str_d1", bus.m0_rd, 32'hA5A5_0004);
    cyc();
    chk("str_v2", 32'(bus.m0_valid), 1);
    chk("str_d2", bus.m0_rd, 32'hA5A5_0008);
    cyc();
    chk("str_end", 32'({bus.m0_valid, bus.m1_valid}), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
